// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer shared definitions.
// Op encodings and default latencies.
package muldiv_sequencer_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// E/D-stage bundle between pipeline and
// the multiply/divide sequencer.
interface muldiv_sequencer_if;
   import muldiv_sequencer_pkg::*;

   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        wr_hi;
   logic        wr_lo;
   logic        md_use_d;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;

   modport master (
      output start, op, a, b,
      output wr_hi, wr_lo, md_use_d,
      input  hi, lo, busy, stall
   );

   modport slave (
      input  start, op, a, b,
      input  wr_hi, wr_lo, md_use_d,
      output hi, lo, busy, stall
   );

endinterface

// File: rtl/muldiv_calc.sv
// Combinational mult/div datapath.
// Result is {hi,lo}.
module muldiv_calc
   import muldiv_sequencer_pkg::*;
(
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o
);

   logic signed [63:0] smul;
   logic        [63:0] umul;
   logic               b_zero;
   logic               ovf;
   logic        [31:0] b_safe;
   logic signed [31:0] squo;
   logic signed [31:0] srem;
   logic        [31:0] uquo;
   logic        [31:0] urem;

   assign smul = $signed({{32{a_i[31]}}, a_i}) *
                 $signed({{32{b_i[31]}}, b_i});
   assign umul = {32'd0, a_i} * {32'd0, b_i};

   assign b_zero = (b_i == 32'd0);
   assign ovf    = (a_i == 32'h8000_0000) &&
                   (b_i == 32'hFFFF_FFFF);

   // Keep the dividers away from /0 and the
   // one signed overflow case; both are muxed
   // to fixed results below.
   assign b_safe = (b_zero || ovf) ? 32'd1 : b_i;

   assign squo = $signed(a_i) / $signed(b_safe);
   assign srem = $signed(a_i) % $signed(b_safe);
   assign uquo = a_i / b_safe;
   assign urem = a_i % b_safe;

   // Select result by op, applying the special cases.
   always_comb begin
      res_o = 64'd0;
      unique case (op_i)
         MD_MULT:  res_o = smul;
         MD_MULTU: res_o = umul;
         MD_DIV: begin
            if (b_zero)
               res_o = {a_i, 32'hFFFF_FFFF};
            else if (ovf)
               res_o = {32'd0, 32'h8000_0000};
            else
               res_o = {srem, squo};
         end
         MD_DIVU: begin
            if (b_zero)
               res_o = {a_i, 32'hFFFF_FFFF};
            else
               res_o = {urem, uquo};
         end
      endcase
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div sequencer owning
// HI/LO, with D-stage stall generation.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input logic clk,
   input logic reset_n,
   muldiv_sequencer_if.slave md
);

   localparam int MAXC =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [CW-1:0] count_q, count_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   pend_hi_q, pend_hi_d;
   logic [31:0]   pend_lo_q, pend_lo_d;
   logic [63:0]   calc_res;
   logic [0:0]    state;
   logic          is_div;

   muldiv_calc u_calc (
      .op_i  (md.op),
      .a_i   (md.a),
      .b_i   (md.b),
      .res_o (calc_res)
   );

   assign state  = (count_q != '0) ? ST_RUN : ST_IDLE;
   assign is_div = (md.op == MD_DIV) || (md.op == MD_DIVU);

   // Next-state: launch, count down, commit, mthi/mtlo.
   always_comb begin
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      unique case (state)
         ST_IDLE: begin
            if (md.start) begin
               count_d   = is_div ? CW'(DIV_CYCLES)
                                  : CW'(MULT_CYCLES);
               pend_hi_d = calc_res[63:32];
               pend_lo_d = calc_res[31:0];
            end else begin
               if (md.wr_hi) hi_d = md.a;
               if (md.wr_lo) lo_d = md.a;
            end
         end
         ST_RUN: begin
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               hi_d = pend_hi_q;
               lo_d = pend_lo_q;
            end
         end
         default: ;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   assign md.hi    = hi_q;
   assign md.lo    = lo_q;
   assign md.busy  = (state == ST_RUN);
   assign md.stall = md.md_use_d & (md.busy | md.start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer.
// Reference model uses 64-bit integer math.
module tb_muldiv_sequencer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   logic [63:0] sbq[$];
   logic [31:0] mhi = 0;
   logic [31:0] mlo = 0;
   logic        busy_prev = 1'b0;

   always #5 clk = ~clk;

   muldiv_sequencer_if md_if ();

   muldiv_sequencer #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .md      (md_if.slave)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h",
                    nm, act, exp);
   endtask

   function automatic int lat(input logic [1:0] op);
      return op[1] ? 10 : 5;
   endfunction

   function automatic logic [63:0] ref_md(
      input logic [1:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
      longint sa, sb, q, r, ma, mb;
      longint unsigned ua, ub;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      res = 64'd0;
      case (op)
         2'd0: res = sa * sb;
         2'd1: res = ua * ub;
         2'd2: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               ma = (sa < 0) ? -sa : sa;
               mb = (sb < 0) ? -sb : sb;
               q = ma / mb;
               if ((sa < 0) != (sb < 0)) q = -q;
               r = sa - q * sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               ua = ua / ub;
               ub = {32'd0, a} % {32'd0, b};
               res = {ub[31:0], ua[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   // Monitor: compare HI/LO against scoreboard on commit
   always @(negedge clk) begin
      if (reset_n && busy_prev && !md_if.busy) begin
         if (sbq.size() == 0) begin
            chk("unexpected_commit", 32'd1, 32'd0);
         end else begin
            logic [63:0] e;
            e = sbq.pop_front();
            chk("commit_hi", md_if.hi, e[63:32]);
            chk("commit_lo", md_if.lo, e[31:0]);
         end
      end
      busy_prev = md_if.busy;
   end

   task automatic clear_in();
      md_if.start = 1'b0;
      md_if.wr_hi = 1'b0;
      md_if.wr_lo = 1'b0;
   endtask

   // Called just after a negedge; ends just after one.
   task automatic run_op(input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic use_d,
                         input bit interfere);
      logic [63:0] e;
      int n;
      e = ref_md(op, a, b);
      n = lat(op);
      md_if.start = 1'b1;
      md_if.op = op;
      md_if.a = a;
      md_if.b = b;
      md_if.md_use_d = use_d;
      #1 chk("stall_start", md_if.stall, use_d);
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         clear_in();
         if (interfere && i == 1) begin
            md_if.start = 1'b1;
            md_if.wr_hi = 1'b1;
            md_if.wr_lo = 1'b1;
            md_if.op = 2'($urandom);
            md_if.a = $urandom;
            md_if.b = $urandom;
         end
         #1;
         chk("busy_run", md_if.busy, 1'b1);
         chk("stall_run", md_if.stall, use_d);
         if (i == n - 1) begin
            chk("hi_hold", md_if.hi, mhi);
            chk("lo_hold", md_if.lo, mlo);
         end
         @(posedge clk);
         @(negedge clk);
      end
      clear_in();
      #1;
      chk("busy_done", md_if.busy, 1'b0);
      chk("stall_done", md_if.stall, 1'b0);
      mhi = e[63:32];
      mlo = e[31:0];
      md_if.md_use_d = 1'b0;
   endtask

   task automatic do_wr(input bit to_hi,
                        input logic [31:0] v);
      md_if.wr_hi = to_hi;
      md_if.wr_lo = !to_hi;
      md_if.a = v;
      @(posedge clk);
      @(negedge clk);
      clear_in();
      #1;
      if (to_hi) mhi = v;
      else mlo = v;
      chk("wr_hi_val", md_if.hi, mhi);
      chk("wr_lo_val", md_if.lo, mlo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout expired");
      $fatal(1);
   end

   initial begin
      clear_in();
      md_if.op = 2'd0;
      md_if.a = 0;
      md_if.b = 0;
      md_if.md_use_d = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_hi", md_if.hi, 32'd0);
      chk("rst_lo", md_if.lo, 32'd0);
      chk("rst_busy", md_if.busy, 1'b0);
      chk("rst_stall", md_if.stall, 1'b0);
      reset_n = 1'b1;
      md_if.md_use_d = 1'b0;
      @(negedge clk);
      #1;

      run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
      chk("mult_hi", md_if.hi, 32'hFFFF_FFFF);
      chk("mult_lo", md_if.lo, 32'hFFFF_FFFA);
      run_op(2'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
      chk("multu_hi", md_if.hi, 32'h2);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
      chk("div_lo", md_if.lo, 32'hFFFF_FFFD);
      chk("div_hi", md_if.hi, 32'hFFFF_FFFF);
      run_op(2'd3, 32'd7, 32'd0, 1'b1, 0);
      chk("divu0_lo", md_if.lo, 32'hFFFF_FFFF);
      chk("divu0_hi", md_if.hi, 32'd7);
      do_wr(0, 32'h1234);
      chk("mtlo_1234", md_if.lo, 32'h1234);
      do_wr(1, 32'hCAFE_F00D);
      run_op(2'd0, 32'd1000, 32'hFFFF_FFF0, 1'b1, 1);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      chk("ovf_lo", md_if.lo, 32'h8000_0000);
      chk("ovf_hi", md_if.hi, 32'd0);
      run_op(2'd3, 32'd100, 32'd7, 1'b1, 0);

      md_if.start = 1'b1;
      md_if.op = 2'd0;
      md_if.a = 32'd9;
      md_if.b = 32'd9;
      @(posedge clk);
      @(negedge clk);
      clear_in();
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("abort_busy", md_if.busy, 1'b0);
      chk("abort_hi", md_if.hi, 32'd0);
      chk("abort_lo", md_if.lo, 32'd0);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      chk("abort_nocommit_hi", md_if.hi, 32'd0);
      chk("abort_nocommit_lo", md_if.lo, 32'd0);
      mhi = 0;
      mlo = 0;

      for (int k = 0; k < 25; k++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 0;
            1: rb = $urandom_range(1, 20);
            2: rb = -$urandom_range(1, 20);
            default: ;
         endcase
         if ($urandom_range(0, 4) == 0)
            do_wr($urandom_range(0, 1) == 1, $urandom);
         run_op(2'($urandom), ra, rb,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0);
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", sbq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
